// File: rtl/psum_xfer_pkg.sv
// psum_xfer_pkg
// Shared constants, FSM state encodings and a width helper for the
// cross-core partial-sum transmit FIFO (psum_xfer_fifo) and its storage array.
//   BW/BW_PSUM/WORD_W  : activation, psum and data-word widths
//   TOTAL_CYCLE/FRAMES : words per frame and number of frame slots
//   DEPTH              : total word slots
// Optional feature macro used by the top: PSUM_XFER_ERR_EN.
package psum_xfer_pkg;

  // Ceiling log2 used to size pointers and counters.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  localparam int BW          = 8;
  localparam int BW_PSUM     = 2 * BW + 4;
  localparam int WORD_W      = BW_PSUM + 4;
  localparam int TOTAL_CYCLE = 16;
  localparam int FRAMES      = 2;
  localparam int DEPTH       = FRAMES * TOTAL_CYCLE;

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(TOTAL_CYCLE);
  localparam int DF_W  = clog2(FRAMES + 1);
  localparam int OCC_W = clog2(DEPTH + 1);

  typedef enum logic { IDLE = 1'b0, FILL  = 1'b1 } wr_state_t;
  typedef enum logic { WAIT = 1'b0, DRAIN = 1'b1 } rd_state_t;

endpackage

// File: rtl/psum_xfer_mem.sv
// psum_xfer_mem
// 1-write/1-read register array of DEPTH x WORD_W. Writes land at the clock
// edge; the read port is registered, so data appears one cycle after rd_en
// and holds its value while rd_en is low.
//   clk, reset (sync, active-low; clears only the read register)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr, rd_data : registered read port
module psum_xfer_mem
  import psum_xfer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage needs no reset: validity is tracked by the pointers in the top.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/psum_xfer_fifo.sv
// psum_xfer_fifo
// Transmit side of the cross-core partial-sum exchange. Buffers the local
// core's sum_out words in frames of TOTAL_CYCLE words and serves them to the
// peer, which pops one word per cycle with fifo_ext_rd.
// Handshake: a push (wr) is accepted when not full, or when full but a pop is
//   accepted in the same cycle; a pop (fifo_ext_rd) is accepted when not empty
//   and its word appears on rd_data one cycle later. Rejected requests leave
//   all state untouched.
// Ports:
//   clk, reset (sync, active-low)
//   wr, wr_data          : local push
//   fifo_ext_rd, rd_data : peer pop, registered data
//   fifo_in_ready        : at least one complete frame buffered (registered)
//   full, empty          : occupancy flags
//   err[1:0]             : sticky {underflow, overflow}, only with PSUM_XFER_ERR_EN
module psum_xfer_fifo
  import psum_xfer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              fifo_ext_rd,
  output logic [WORD_W-1:0] rd_data,
  output logic              fifo_in_ready,
  output logic              full,
  output logic              empty
`ifdef PSUM_XFER_ERR_EN
  ,
  output logic [1:0]        err
`endif
);

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] wcnt, rcnt;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic [DF_W-1:0]  done_frames, done_frames_nxt;
  logic             wr_fire, rd_fire, wr_wrap, rd_wrap;
  wr_state_t        wr_state, wr_state_nxt;
  rd_state_t        rd_state, rd_state_nxt;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

  // A pop on a full FIFO frees a slot, so the same-cycle push is accepted.
  assign rd_fire = fifo_ext_rd && !empty;
  assign wr_fire = wr && (!full || rd_fire);
  assign wr_wrap = wr_fire && (wcnt == CNT_W'(TOTAL_CYCLE - 1));
  assign rd_wrap = rd_fire && (rcnt == CNT_W'(TOTAL_CYCLE - 1));

  psum_xfer_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_fire),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rptr),
    .rd_data (rd_data)
  );

  always_comb begin
    occ_nxt = occ;
    if (wr_fire && !rd_fire) begin
      occ_nxt = occ + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      occ_nxt = occ - 1'b1;
    end
  end

  // A frame completing and one being consumed in the same cycle cancel out.
  always_comb begin
    done_frames_nxt = done_frames;
    if (wr_wrap && !rd_wrap) begin
      done_frames_nxt = done_frames + 1'b1;
    end else if (rd_wrap && !wr_wrap) begin
      done_frames_nxt = done_frames - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr          <= '0;
      rptr          <= '0;
      wcnt          <= '0;
      rcnt          <= '0;
      occ           <= '0;
      done_frames   <= '0;
      fifo_in_ready <= 1'b0;
      wr_state      <= IDLE;
      rd_state      <= WAIT;
    end else begin
      if (wr_fire) begin
        wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
        wcnt <= (wcnt == CNT_W'(TOTAL_CYCLE - 1)) ? '0 : wcnt + 1'b1;
      end
      if (rd_fire) begin
        rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + 1'b1;
        rcnt <= (rcnt == CNT_W'(TOTAL_CYCLE - 1)) ? '0 : rcnt + 1'b1;
      end
      occ           <= occ_nxt;
      done_frames   <= done_frames_nxt;
      fifo_in_ready <= (done_frames_nxt != '0);
      wr_state      <= wr_state_nxt;
      rd_state      <= rd_state_nxt;
    end
  end

  // Write-side frame tracker: returns to IDLE once the last slot is filled.
  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      IDLE: if (wr_fire) wr_state_nxt = FILL;
      FILL: if (wr_wrap && (done_frames == DF_W'(FRAMES - 1))) wr_state_nxt = IDLE;
      default: wr_state_nxt = IDLE;
    endcase
  end

  // Read-side frame tracker: one DRAIN pass per frame handed to the peer.
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      WAIT:  if (fifo_ext_rd && fifo_in_ready) rd_state_nxt = DRAIN;
      DRAIN: if (rd_wrap) rd_state_nxt = WAIT;
      default: rd_state_nxt = WAIT;
    endcase
  end

`ifdef PSUM_XFER_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 2'b00;
    end else begin
      if (wr && !wr_fire)      err[0] <= 1'b1;
      if (fifo_ext_rd && empty) err[1] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psum_xfer_fifo.sv
// tb_psum_xfer_fifo
// Self-checking bench for psum_xfer_fifo: a reference FIFO model feeds an
// expected queue, a table of vectors covers the frame-ready boundary, and
// hand-written sequences cover overflow, concurrent traffic, underflow and
// mid-frame reset. Build with PSUM_XFER_ERR_EN to also check err.
module tb_psum_xfer_fifo;
  import psum_xfer_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              fifo_ext_rd = 1'b0;
  logic [WORD_W-1:0] rd_data;
  logic              fifo_in_ready, full, empty;
`ifdef PSUM_XFER_ERR_EN
  logic [1:0]        err;
`endif

  always #5 clk = ~clk;

  psum_xfer_fifo dut (
    .clk           (clk),
    .reset         (reset),
    .wr            (wr),
    .wr_data       (wr_data),
    .fifo_ext_rd   (fifo_ext_rd),
    .rd_data       (rd_data),
    .fifo_in_ready (fifo_in_ready),
    .full          (full),
    .empty         (empty)
`ifdef PSUM_XFER_ERR_EN
    ,
    .err           (err)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [WORD_W-1:0] mdl[$];
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] last_rd;
  int m_wcnt, m_rcnt, m_frames;
  logic m_err0, m_err1;

  typedef struct {
    logic              wr;
    logic [WORD_W-1:0] data;
    logic              rd;
    logic              exp_ready;
    logic              exp_empty;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("full",  {31'b0, full},          {31'b0, mdl.size() == DEPTH});
    check("empty", {31'b0, empty},         {31'b0, mdl.size() == 0});
    check("ready", {31'b0, fifo_in_ready}, {31'b0, m_frames != 0});
`ifdef PSUM_XFER_ERR_EN
    check("err", {30'b0, err}, {30'b0, m_err1, m_err0});
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0; wr = 1'b0; fifo_ext_rd = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    mdl.delete(); exp_q.delete();
    last_rd = '0; m_wcnt = 0; m_rcnt = 0; m_frames = 0;
    m_err0 = 1'b0; m_err1 = 1'b0;
    check("reset_rd_data", {8'b0, rd_data}, 32'h0);
    check_flags();
  endtask

  // One clock cycle of stimulus; the model decides acceptance from its own
  // occupancy, and results are compared #1 after the edge.
  task automatic cycle(input logic w, input logic [WORD_W-1:0] d, input logic r);
    bit rd_ok, wr_ok;
    wr = w; wr_data = d; fifo_ext_rd = r;
    rd_ok = r && (mdl.size() != 0);
    wr_ok = w && ((mdl.size() < DEPTH) || rd_ok);
    if (w && !wr_ok) m_err0 = 1'b1;
    if (r && mdl.size() == 0) m_err1 = 1'b1;
    if (rd_ok) begin
      exp_q.push_back(mdl.pop_front());
      if (m_rcnt == TOTAL_CYCLE - 1) begin m_rcnt = 0; m_frames--; end
      else m_rcnt++;
    end
    if (wr_ok) begin
      mdl.push_back(d);
      if (m_wcnt == TOTAL_CYCLE - 1) begin m_wcnt = 0; m_frames++; end
      else m_wcnt++;
    end
    @(posedge clk); #1;
    wr = 1'b0; fifo_ext_rd = 1'b0;
    if (rd_ok) begin
      logic [WORD_W-1:0] e;
      e = exp_q.pop_front();
      check("rd_data", {8'b0, rd_data}, {8'b0, e});
      last_rd = e;
    end else begin
      check("rd_hold", {8'b0, rd_data}, {8'b0, last_rd});
    end
    check_flags();
  endtask

  initial begin
    // 1. One frame in, ready after the 16th, drained in order.
    do_reset();
    for (int i = 1; i <= 16; i++) cycle(1'b1, WORD_W'(i), 1'b0);
    check("t1_ready_after_16", {31'b0, fifo_in_ready}, 32'h1);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    check("t1_empty_end", {31'b0, empty}, 32'h1);
    check("t1_ready_end", {31'b0, fifo_in_ready}, 32'h0);

    // 2. Table: 15 writes keep ready low, 16th raises it, 4 pops keep it.
    for (int i = 0; i < 20; i++) begin
      tbl[i].wr        = (i < 16);
      tbl[i].data      = WORD_W'(24'h200 + i);
      tbl[i].rd        = (i >= 16);
      tbl[i].exp_ready = (i >= 15);
      tbl[i].exp_empty = 1'b0;
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(tbl[i].wr, tbl[i].data, tbl[i].rd);
      check("tbl_ready", {31'b0, fifo_in_ready}, {31'b0, tbl[i].exp_ready});
      check("tbl_empty", {31'b0, empty},         {31'b0, tbl[i].exp_empty});
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);

    // 3. Fill both frames, overflow drops 0xABCDE, full-cycle rd+wr, drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WORD_W'($urandom_range(16'hFFFF, 0)), 1'b0);
    check("t3_full", {31'b0, full}, 32'h1);
    cycle(1'b1, 24'hABCDE, 1'b0);
`ifdef PSUM_XFER_ERR_EN
    check("t3_err0", {31'b0, err[0]}, 32'h1);
`endif
    cycle(1'b1, 24'h5A5A5, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);

    // 4. Concurrent streaming behind one buffered frame.
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, WORD_W'(24'h300 + i), 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, WORD_W'(24'h400 + i), 1'b1);
      check("t4_ready_held", {31'b0, fifo_in_ready}, 32'h1);
      check("t4_not_full", {31'b0, full}, 32'h0);
    end
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);

    // 5. Pop on empty holds rd_data.
    cycle(1'b0, '0, 1'b1);
    check("t5_hold", {8'b0, rd_data}, {8'b0, 24'h40F});
`ifdef PSUM_XFER_ERR_EN
    check("t5_err1", {31'b0, err[1]}, 32'h1);
`endif

    // 6. Reset mid-frame discards data; a fresh frame reads from slot 0.
    for (int i = 0; i < 8; i++) cycle(1'b1, WORD_W'(24'h500 + i), 1'b0);
    do_reset();
    check("t6_empty", {31'b0, empty}, 32'h1);
    check("t6_ready", {31'b0, fifo_in_ready}, 32'h0);
    for (int i = 0; i < 16; i++) cycle(1'b1, WORD_W'(24'h600 + i), 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1);
    check("t6_last", {8'b0, rd_data}, {8'b0, 24'h60F});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
